dcache_fill_unit: RTL
=====================

Name: dcache_fill_unit

Overview:
- Line-fill stage directly upstream of the dcache data SRAM write port.
- Accepts a fill request (target row plus critical word), collects WIDTH/WORD_SIZE beats from the memory side in wrap-around order starting at the critical word, and forwards the critical word early to the load path.
- Commits the assembled line to the SRAM in a single full-row write cycle.

Parameters:
- WIDTH, 512, line/SRAM row width in bits
- LOG_NUM_ROWS, 9, SRAM row index width
- WORD_SIZE, 64, beat width and SRAM write-enable granularity
- NUM_WORDS (localparam), WIDTH/WORD_SIZE = 8, beats per line
- LOG_NUM_WORDS (localparam), $clog2(NUM_WORDS) = 3

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fill_req_valid  in  1  fill request present
- fill_req_ready  out  1  unit can accept a request
- fill_req_row  in  LOG_NUM_ROWS  destination SRAM row
- fill_req_word  in  LOG_NUM_WORDS  critical (first-delivered) word index
- beat_valid  in  1  memory beat present
- beat_ready  out  1  unit accepts beat
- beat_data  in  WORD_SIZE  beat payload
- crit_valid  out  1  one-cycle pulse: critical word available
- crit_data  out  WORD_SIZE  critical word payload
- writeAddr  out  LOG_NUM_ROWS  to SRAM writeAddr
- writeData  out  WIDTH  to SRAM writeData
- writeEnable  out  NUM_WORDS  to SRAM writeEnable
- fill_done  out  1  one-cycle pulse: line committed
- fill_done_row  out  LOG_NUM_ROWS  row committed with fill_done

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port named reset.
- States: IDLE, COLLECT, COMMIT.
- Reset:
  - state = IDLE; line buffer, beat counter, latched row and word cleared.
  - All outputs 0, except fill_req_ready = 1 once in IDLE.
- IDLE:
  - fill_req_ready = 1.
  - On fill_req_valid: latch row to writeAddr, word to wptr, cnt = 0, go to COLLECT.
- COLLECT:
  - beat_ready = 1; fill_req_ready = 0.
  - On beat_valid && beat_ready: store beat_data at buffer word wptr, i.e. bits [wptr*WORD_SIZE +: WORD_SIZE].
  - Then wptr = (wptr + 1) mod NUM_WORDS; wrap from NUM_WORDS-1 to 0 is required; cnt += 1.
  - First accepted beat (cnt == 0): crit_valid = 1 and crit_data = beat_data, registered, asserted the cycle after acceptance for exactly 1 cycle.
  - When the beat with cnt == NUM_WORDS-1 is accepted, go to COMMIT.
  - beat_valid low stalls indefinitely; no timeout.
- COMMIT (exactly 1 cycle):
  - writeEnable = all ones; writeData = assembled buffer; writeAddr = latched row.
  - fill_done = 1; fill_done_row = latched row.
  - Next state IDLE.
  - The SRAM captures the row on this cycle's edge; it is readable via the SRAM read port from the following cycle, with that port's one-cycle read latency.
- Outside COMMIT: writeEnable = 0 and fill_done = 0; writeAddr and writeData hold their last values.
- Back-to-back: a request is accepted in the IDLE cycle after COMMIT. Minimum period per fill is NUM_WORDS + 2 cycles.
- Beats presented in IDLE or COMMIT are not accepted (beat_ready = 0).
- Requests in COLLECT or COMMIT are not accepted; they must hold until fill_req_ready.
- Reset asserted mid-COLLECT or in COMMIT:
  - Fill is abandoned; no write is issued that cycle or later.
  - crit_valid and fill_done are forced 0; partial buffer is discarded.
- Single write port: the unit never asserts a partial writeEnable.

Test Plan:
- Reset, then req row=5 word=0, beats 0x0..0x7 back-to-back:
  - crit_valid with 0x0 one cycle after the first beat.
  - COMMIT on cycle 10 after request: writeAddr=5, writeEnable=8'hFF, word i = i, fill_done_row=5.
- Req row=511 word=6, beats A0..A7:
  - Word6=A0, word7=A1, word0=A2, ..., word5=A7.
  - crit_data=A0; wrap verified.
- Req row=3 word=2, beat_valid toggled every other cycle:
  - Exactly 8 beats accepted; COMMIT follows the 8th beat.
  - No writeEnable before then; crit pulse exactly once.
- Second request held high during COLLECT and COMMIT:
  - fill_req_ready = 0 until IDLE.
  - Second fill accepted in the cycle after fill_done; both rows written correctly.
- Reset asserted after 4 beats of row=7:
  - writeEnable never asserted; fill_req_ready = 1 after reset.
  - A new fill to row=7 yields only the new data.
- Beats driven in IDLE with no request:
  - beat_ready = 0; no crit_valid, no writeEnable.

Source files
------------

// File: rtl/dcache_fill_unit_if.sv
// Bus bundle between the dcache fill unit and its neighbours: the fill
// request, the memory beat stream, the critical-word bypass to the load
// path and the full-row write port of the data SRAM.
interface dcache_fill_unit_if #(
  parameter int WIDTH        = 512,
  parameter int LOG_NUM_ROWS = 9,
  parameter int WORD_SIZE    = 64
);
  localparam int NUM_WORDS     = WIDTH / WORD_SIZE;
  localparam int LOG_NUM_WORDS = $clog2(NUM_WORDS);

  // Fill request
  logic                     fill_req_valid;
  logic                     fill_req_ready;
  logic [LOG_NUM_ROWS-1:0]  fill_req_row;
  logic [LOG_NUM_WORDS-1:0] fill_req_word;

  // Memory beats
  logic                     beat_valid;
  logic                     beat_ready;
  logic [WORD_SIZE-1:0]     beat_data;

  // Critical-word bypass
  logic                     crit_valid;
  logic [WORD_SIZE-1:0]     crit_data;

  // SRAM write port and completion
  logic [LOG_NUM_ROWS-1:0]  writeAddr;
  logic [WIDTH-1:0]         writeData;
  logic [NUM_WORDS-1:0]     writeEnable;
  logic                     fill_done;
  logic [LOG_NUM_ROWS-1:0]  fill_done_row;

  // Requester / memory / SRAM side
  modport master (
    output fill_req_valid, fill_req_row, fill_req_word, beat_valid, beat_data,
    input  fill_req_ready, beat_ready, crit_valid, crit_data,
           writeAddr, writeData, writeEnable, fill_done, fill_done_row
  );

  // Fill unit side
  modport slave (
    input  fill_req_valid, fill_req_row, fill_req_word, beat_valid, beat_data,
    output fill_req_ready, beat_ready, crit_valid, crit_data,
           writeAddr, writeData, writeEnable, fill_done, fill_done_row
  );
endinterface

// File: rtl/dcache_fill_unit.sv
// Dcache line-fill unit: accepts a fill request, gathers one line of beats in
// wrap-around order starting at the critical word, forwards the critical word
// early, then commits the whole line to the SRAM in one full-row write.
// NUM_WORDS must be a power of two so the word pointer wraps naturally.
module dcache_fill_unit #(
  parameter int WIDTH        = 512,
  parameter int LOG_NUM_ROWS = 9,
  parameter int WORD_SIZE    = 64
) (
  input  logic                clk,
  input  logic                reset,
  dcache_fill_unit_if.slave   bus
);
  localparam int NUM_WORDS     = WIDTH / WORD_SIZE;
  localparam int LOG_NUM_WORDS = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                                  state_q, state_d;
  logic [LOG_NUM_ROWS-1:0]                 row_q, row_d;
  logic [LOG_NUM_WORDS-1:0]                wptr_q, wptr_d;
  logic [LOG_NUM_WORDS-1:0]                cnt_q, cnt_d;
  logic [NUM_WORDS-1:0][WORD_SIZE-1:0]     line_q, line_d;
  logic                                    crit_valid_q, crit_valid_d;
  logic [WORD_SIZE-1:0]                    crit_data_q, crit_data_d;
  logic                                    beat_acc;

  // State, latched request, pointer/counter, line buffer and bypass registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  // Next-state logic: request latch, beat acceptance and critical-word capture
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    beat_acc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fill_req_valid) begin
          row_d   = bus.fill_req_row;
          wptr_d  = bus.fill_req_word;
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.beat_valid) begin
          beat_acc = 1'b1;
          wptr_d   = wptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          // The first beat delivered is the critical word.
          if (cnt_q == '0) begin
            crit_valid_d = 1'b1;
            crit_data_d  = bus.beat_data;
          end
          if (cnt_q == LOG_NUM_WORDS'(NUM_WORDS - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Per-word buffer update: only the word under the pointer takes the beat
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign line_d[gi] = (beat_acc && (wptr_q == LOG_NUM_WORDS'(gi)))
                          ? bus.beat_data : line_q[gi];
    end
  endgenerate

  // Outputs; reset gates the handshakes and strobes combinationally so an
  // abandoned fill never issues a write, even in the cycle reset arrives.
  logic commit_act;
  assign commit_act         = (state_q == COMMIT) && !reset;
  assign bus.fill_req_ready = (state_q == IDLE) && !reset;
  assign bus.beat_ready     = (state_q == COLLECT) && !reset;
  assign bus.crit_valid     = crit_valid_q && !reset;
  assign bus.crit_data      = crit_data_q;
  assign bus.writeAddr      = row_q;
  assign bus.writeData      = line_q;
  assign bus.writeEnable    = {NUM_WORDS{commit_act}};
  assign bus.fill_done      = commit_act;
  assign bus.fill_done_row  = row_q;

endmodule
